// File: rtl/ff_sample_sequencer.sv
// Sample sequencer: buffers host AER events per sample and replays them to the FF core.
// Optional output-spike counter enabled by defining FF_SEQ_SPIKE_CNT_EN.
module ff_sample_sequencer #(
  parameter int unsigned AER_W     = 12,
  parameter int unsigned OUT_W     = 10,
  parameter int unsigned GOOD_W    = 32,
  parameter int unsigned EVT_DEPTH = 1024,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [AER_W-1:0]  EVT_DATA,
  input  logic              EVT_LAST,
  input  logic              EVT_VALID,
  output logic              EVT_READY,
  input  logic              START,
  input  logic              CMD_POS,
  input  logic              CMD_TRAIN,
  input  logic              CMD_PAIR,
  output logic [AER_W-1:0]  AERIN_ADDR,
  output logic              AERIN_REQ,
  input  logic              AERIN_ACK,
  input  logic [OUT_W-1:0]  AEROUT_ADDR,
  input  logic              AEROUT_REQ,
  output logic              AEROUT_ACK,
  output logic              IS_POS,
  output logic              IS_TRAIN,
  input  logic [GOOD_W-1:0] GOODNESS,
  input  logic              ONE_SAMPLE_FINISH,
  output logic              BUSY,
  output logic              RESULT_VALID,
  output logic [GOOD_W-1:0] RESULT_GOOD,
  output logic [GOOD_W:0]   RESULT_DIFF,
  output logic [15:0]       RESULT_SPIKES,
  output logic              ERR_TIMEOUT
);

  localparam int unsigned PTR_W = $clog2(EVT_DEPTH);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef logic [PTR_W:0] ptr_t;
  typedef logic [WD_W-1:0] wd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WACK, S_WREL, S_WFIN, S_REPLAY, S_FLUSH, S_DONE
  } state_t;

  state_t state_q, state_d;
  ptr_t wp_q, wp_d, rp_q, rp_d, cp_q, cp_d, samp_cnt_q, samp_cnt_d;
  logic rdy_q;
  logic sent_last_q, sent_last_d;
  logic pair_q, pair_d, is_pos_q, is_pos_d, is_train_q, is_train_d;
  logic [GOOD_W-1:0] good_a_q, good_a_d, good_b_q, good_b_d;
  logic [GOOD_W-1:0] res_good_q, res_good_d;
  logic [GOOD_W:0]   res_diff_q, res_diff_d;
  logic res_valid_q, res_valid_d, err_q, err_d;
  wd_t  wd_q, wd_d;
  logic aerout_ack_q;

  logic [AER_W:0] mem_q [EVT_DEPTH];
  logic [AER_W:0] rd_entry;
  logic           rd_last, full, wr_en, start_acc, wait_st, timeout, commit;
  ptr_t           occupancy;
  logic           unused_aerout_addr;

  assign unused_aerout_addr = ^AEROUT_ADDR;

  // Extra pointer bit distinguishes full from empty when cp and wp alias.
  assign occupancy = wp_q - cp_q;
  assign full      = occupancy[PTR_W];
  assign EVT_READY = rdy_q & ~full;
  assign wr_en     = EVT_VALID & EVT_READY;
  assign rd_entry  = mem_q[rp_q[PTR_W-1:0]];
  assign rd_last   = rd_entry[AER_W];
  assign start_acc = (state_q == S_IDLE) && START && (samp_cnt_q != '0);
  assign wait_st   = (state_q == S_WACK) || (state_q == S_WREL) || (state_q == S_WFIN);
  assign timeout   = wait_st && (wd_q == wd_t'(TIMEOUT - 1));

  assign AERIN_REQ    = (state_q == S_REQ) || (state_q == S_WACK);
  assign AERIN_ADDR   = AERIN_REQ ? rd_entry[AER_W-1:0] : '0;
  assign AEROUT_ACK   = aerout_ack_q;
  assign IS_POS       = is_pos_q;
  assign IS_TRAIN     = is_train_q;
  assign BUSY         = (state_q != S_IDLE);
  assign RESULT_VALID = res_valid_q;
  assign RESULT_GOOD  = res_good_q;
  assign RESULT_DIFF  = res_diff_q;
  assign ERR_TIMEOUT  = err_q;

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wp_q[PTR_W-1:0]] <= {EVT_LAST, EVT_DATA};
  end

  always_comb begin
    state_d     = state_q;
    wp_d        = wr_en ? wp_q + ptr_t'(1) : wp_q;
    rp_d        = rp_q;
    cp_d        = cp_q;
    samp_cnt_d  = samp_cnt_q;
    sent_last_d = sent_last_q;
    pair_d      = pair_q;
    is_pos_d    = is_pos_q;
    is_train_d  = is_train_q;
    good_a_d    = good_a_q;
    good_b_d    = good_b_q;
    res_good_d  = res_good_q;
    res_diff_d  = res_diff_q;
    res_valid_d = 1'b0;
    err_d       = 1'b0;
    commit      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d     = S_REQ;
          pair_d      = CMD_PAIR;
          is_pos_d    = CMD_PAIR | CMD_POS;
          is_train_d  = CMD_TRAIN;
          sent_last_d = 1'b0;
        end
      end
      S_REQ: state_d = S_WACK;
      S_WACK: begin
        if (timeout) state_d = S_FLUSH;
        else if (AERIN_ACK) begin
          rp_d        = rp_q + ptr_t'(1);
          sent_last_d = rd_last;
          state_d     = S_WREL;
        end
      end
      S_WREL: begin
        if (timeout) state_d = S_FLUSH;
        else if (!AERIN_ACK) state_d = sent_last_q ? S_WFIN : S_REQ;
      end
      S_WFIN: begin
        if (timeout) state_d = S_FLUSH;
        else if (ONE_SAMPLE_FINISH) begin
          if (pair_q && !is_pos_q) good_b_d = GOODNESS;
          else                     good_a_d = GOODNESS;
          state_d = (pair_q && is_pos_q) ? S_REPLAY : S_DONE;
        end
      end
      S_REPLAY: begin
        rp_d        = cp_q;
        is_pos_d    = 1'b0;
        sent_last_d = 1'b0;
        state_d     = S_REQ;
      end
      // Skip the unsent tail of the sample; sent_last marks that LAST is already consumed.
      S_FLUSH: begin
        if (sent_last_q) begin
          commit  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          rp_d        = rp_q + ptr_t'(1);
          sent_last_d = rd_last;
        end
      end
      S_DONE: begin
        commit      = 1'b1;
        res_valid_d = 1'b1;
        res_good_d  = good_a_q;
        res_diff_d  = pair_q ? ({good_a_q[GOOD_W-1], good_a_q} - {good_b_q[GOOD_W-1], good_b_q})
                             : '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) cp_d = rp_q;
    unique case ({wr_en & EVT_LAST, commit})
      2'b10:   samp_cnt_d = samp_cnt_q + ptr_t'(1);
      2'b01:   samp_cnt_d = samp_cnt_q - ptr_t'(1);
      default: samp_cnt_d = samp_cnt_q;
    endcase

    wd_d = (wait_st && (state_d == state_q)) ? wd_q + wd_t'(1) : '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      wp_q         <= '0;
      rp_q         <= '0;
      cp_q         <= '0;
      samp_cnt_q   <= '0;
      rdy_q        <= 1'b0;
      sent_last_q  <= 1'b0;
      pair_q       <= 1'b0;
      is_pos_q     <= 1'b0;
      is_train_q   <= 1'b0;
      good_a_q     <= '0;
      good_b_q     <= '0;
      res_good_q   <= '0;
      res_diff_q   <= '0;
      res_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      wd_q         <= '0;
      aerout_ack_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      cp_q         <= cp_d;
      samp_cnt_q   <= samp_cnt_d;
      rdy_q        <= 1'b1;
      sent_last_q  <= sent_last_d;
      pair_q       <= pair_d;
      is_pos_q     <= is_pos_d;
      is_train_q   <= is_train_d;
      good_a_q     <= good_a_d;
      good_b_q     <= good_b_d;
      res_good_q   <= res_good_d;
      res_diff_q   <= res_diff_d;
      res_valid_q  <= res_valid_d;
      err_q        <= err_d;
      wd_q         <= wd_d;
      aerout_ack_q <= AEROUT_REQ;
    end
  end

`ifdef FF_SEQ_SPIKE_CNT_EN
  logic [15:0] spike_cnt_q, spike_cnt_d, res_spikes_q, res_spikes_d;

  always_comb begin
    spike_cnt_d  = spike_cnt_q;
    res_spikes_d = res_spikes_q;
    if (start_acc) spike_cnt_d = '0;
    else if (AEROUT_REQ && !aerout_ack_q && (spike_cnt_q != '1))
      spike_cnt_d = spike_cnt_q + 16'd1;
    if (state_q == S_DONE) res_spikes_d = spike_cnt_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      spike_cnt_q  <= '0;
      res_spikes_q <= '0;
    end else begin
      spike_cnt_q  <= spike_cnt_d;
      res_spikes_q <= res_spikes_d;
    end
  end

  assign RESULT_SPIKES = res_spikes_q;
`else
  assign RESULT_SPIKES = '0;
`endif

endmodule

// File: tb/tb_ff_sample_sequencer.sv
// Directed bench for ff_sample_sequencer: core responder model plus AERIN scoreboard.
module tb_ff_sample_sequencer;

  localparam int unsigned AER_W = 12;
  localparam int unsigned OUT_W = 10;
  localparam int unsigned GOOD_W = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO = 100;
`ifdef FF_SEQ_SPIKE_CNT_EN
  localparam logic [15:0] EXP_SPIKES = 16'd4;
`else
  localparam logic [15:0] EXP_SPIKES = 16'd0;
`endif

  logic CLK = 1'b0, RST = 1'b0;
  logic [AER_W-1:0] EVT_DATA = '0;
  logic EVT_LAST = 1'b0, EVT_VALID = 1'b0, EVT_READY;
  logic START = 1'b0, CMD_POS = 1'b0, CMD_TRAIN = 1'b0, CMD_PAIR = 1'b0;
  logic [AER_W-1:0] AERIN_ADDR;
  logic AERIN_REQ, AERIN_ACK;
  logic [OUT_W-1:0] AEROUT_ADDR = '0;
  logic AEROUT_REQ = 1'b0, AEROUT_ACK;
  logic IS_POS, IS_TRAIN;
  logic [GOOD_W-1:0] GOODNESS = '0;
  logic ONE_SAMPLE_FINISH = 1'b0;
  logic BUSY, RESULT_VALID, ERR_TIMEOUT;
  logic [GOOD_W-1:0] RESULT_GOOD;
  logic [GOOD_W:0] RESULT_DIFF;
  logic [15:0] RESULT_SPIKES;

  int n_vec = 0, n_err = 0;
  int hs_total = 0, rv_cnt = 0, err_cnt = 0;
  int unsigned cyc = 0;
  logic [AER_W:0] exp_q[$];
  int unsigned rise_cyc[$];
  logic skip_en = 1'b0;
  logic [AER_W-1:0] skip_addr = '0;
  logic req_prev = 1'b0;
  logic [AER_W-1:0] addr_prev = '0;

  ff_sample_sequencer #(
    .AER_W(AER_W), .OUT_W(OUT_W), .GOOD_W(GOOD_W), .EVT_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .EVT_DATA(EVT_DATA), .EVT_LAST(EVT_LAST), .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY),
    .START(START), .CMD_POS(CMD_POS), .CMD_TRAIN(CMD_TRAIN), .CMD_PAIR(CMD_PAIR),
    .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ), .AERIN_ACK(AERIN_ACK),
    .AEROUT_ADDR(AEROUT_ADDR), .AEROUT_REQ(AEROUT_REQ), .AEROUT_ACK(AEROUT_ACK),
    .IS_POS(IS_POS), .IS_TRAIN(IS_TRAIN),
    .GOODNESS(GOODNESS), .ONE_SAMPLE_FINISH(ONE_SAMPLE_FINISH),
    .BUSY(BUSY), .RESULT_VALID(RESULT_VALID), .RESULT_GOOD(RESULT_GOOD),
    .RESULT_DIFF(RESULT_DIFF), .RESULT_SPIKES(RESULT_SPIKES), .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Core model: acks one cycle after REQ unless the address is being stalled.
  always @(posedge CLK or negedge RST) begin
    if (!RST) AERIN_ACK <= 1'b0;
    else      AERIN_ACK <= AERIN_REQ && !(skip_en && (AERIN_ADDR == skip_addr));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    logic [AER_W:0] e;
    if (RST && AERIN_REQ && !req_prev) begin
      hs_total++;
      rise_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("aerin_unexpected", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("aerin_addr", 64'(AERIN_ADDR), 64'(e[AER_W-1:0]));
        chk("aerin_is_pos", 64'(IS_POS), 64'(e[AER_W]));
      end
    end else if (RST && AERIN_REQ && req_prev) begin
      chk("aerin_addr_stable", 64'(AERIN_ADDR), 64'(addr_prev));
    end
    req_prev  = RST & AERIN_REQ;
    addr_prev = AERIN_ADDR;
    if (RESULT_VALID) rv_cnt++;
    if (ERR_TIMEOUT) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic wr(input logic [AER_W-1:0] a, input logic l);
    EVT_DATA = a; EVT_LAST = l; EVT_VALID = 1'b1;
    tick(1);
    EVT_VALID = 1'b0; EVT_LAST = 1'b0;
  endtask

  task automatic push(input logic [AER_W-1:0] a, input logic pos);
    exp_q.push_back({pos, a});
  endtask

  task automatic start_run(input logic p, input logic t, input logic pr);
    CMD_POS = p; CMD_TRAIN = t; CMD_PAIR = pr; START = 1'b1;
    tick(1);
    START = 1'b0; CMD_POS = 1'b0; CMD_TRAIN = 1'b0; CMD_PAIR = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int k = 0;
    while (hs_total < target && k < 300) begin tick(1); k++; end
    chk("wait_handshakes", 64'(hs_total >= target), 64'd1);
  endtask

  task automatic finish_core(input logic [GOOD_W-1:0] g);
    tick(6);
    GOODNESS = g; ONE_SAMPLE_FINISH = 1'b1;
    tick(1);
    ONE_SAMPLE_FINISH = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [GOOD_W-1:0] good,
                            input logic [GOOD_W:0] diff);
    chk({tag, "_rv_early"}, 64'(RESULT_VALID), 64'd0);
    chk({tag, "_busy_done"}, 64'(BUSY), 64'd1);
    tick(1);
    chk({tag, "_rv"}, 64'(RESULT_VALID), 64'd1);
    chk({tag, "_busy_fall"}, 64'(BUSY), 64'd0);
    chk({tag, "_good"}, 64'(RESULT_GOOD), 64'(good));
    chk({tag, "_diff"}, 64'(RESULT_DIFF), 64'(diff));
    tick(1);
    chk({tag, "_rv_pulse"}, 64'(RESULT_VALID), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int hs0, rv0, err0, k;
    logic [GOOD_W:0] ediff;

    // Reset values
    tick(3);
    chk("rst_outputs", {EVT_READY, AERIN_REQ, AEROUT_ACK, IS_POS, IS_TRAIN, BUSY,
                        RESULT_VALID, ERR_TIMEOUT}, 64'd0);
    chk("rst_addr", 64'(AERIN_ADDR), 64'd0);
    chk("rst_results", {RESULT_GOOD, RESULT_SPIKES}, 64'd0);
    chk("rst_diff", 64'(RESULT_DIFF), 64'd0);
    RST = 1'b1;
    chk("rel_ready_low", 64'(EVT_READY), 64'd0);
    tick(1);
    chk("rel_ready_high", 64'(EVT_READY), 64'd1);

    // Single run with AEROUT traffic
    push(12'h005, 1'b1); push(12'h123, 1'b1); push(12'h30F, 1'b1);
    wr(12'h005, 1'b0); wr(12'h123, 1'b0); wr(12'h30F, 1'b1);
    rise_cyc.delete();
    hs0 = hs_total;
    start_run(1'b1, 1'b0, 1'b0);
    chk("start_busy", 64'(BUSY), 64'd1);
    chk("start_req", 64'(AERIN_REQ), 64'd1);
    for (int i = 0; i < 4; i++) begin
      AEROUT_REQ = 1'b1;
      chk("aerout_ack_pre", 64'(AEROUT_ACK), 64'd0);
      tick(1);
      chk("aerout_ack_rise", 64'(AEROUT_ACK), 64'd1);
      AEROUT_REQ = 1'b0;
      tick(1);
      chk("aerout_ack_fall", 64'(AEROUT_ACK), 64'd0);
    end
    wait_hs(hs0 + 3);
    finish_core(32'h64);
    check_done("single", 32'h64, '0);
    chk("single_spikes", 64'(RESULT_SPIKES), 64'(EXP_SPIKES));
    chk("single_is_pos_held", 64'(IS_POS), 64'd1);
    chk("single_hs_gap1", 64'(rise_cyc.size() >= 3 ? rise_cyc[1] - rise_cyc[0] : 0), 64'd4);
    chk("single_hs_gap2", 64'(rise_cyc.size() >= 3 ? rise_cyc[2] - rise_cyc[1] : 0), 64'd4);

    // Pair run: positive then negative phase
    for (int p = 1; p >= 0; p--) begin
      push(12'h005, p[0]); push(12'h123, p[0]); push(12'h30F, p[0]);
    end
    wr(12'h005, 1'b0); wr(12'h123, 1'b0); wr(12'h30F, 1'b1);
    hs0 = hs_total;
    start_run(1'b0, 1'b0, 1'b1);
    chk("pair_is_pos_forced", 64'(IS_POS), 64'd1);
    wait_hs(hs0 + 3);
    finish_core(32'd200);
    wait_hs(hs0 + 6);
    chk("pair_is_pos_neg", 64'(IS_POS), 64'd0);
    finish_core(32'd350);
    ediff = {1'b0, 32'd200} - {1'b0, 32'd350};
    check_done("pair", 32'd200, ediff);
    chk("pair_spikes_cleared", 64'(RESULT_SPIKES), 64'd0);
    start_run(1'b1, 1'b0, 1'b0);
    chk("pair_buffer_empty", 64'(BUSY), 64'd0);

    // Fill to depth without LAST
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk("fill_ready", 64'(EVT_READY), 64'd1);
      wr(12'h100 + 12'(i), 1'b0);
    end
    chk("full_ready_low", 64'(EVT_READY), 64'd0);
    wr(12'hABC, 1'b1);
    start_run(1'b1, 1'b0, 1'b0);
    chk("full_start_ignored", 64'(BUSY), 64'd0);
    RST = 1'b0;
    #1;
    chk("full_rst_ready", 64'(EVT_READY), 64'd0);
    tick(2);
    RST = 1'b1;
    tick(1);
    chk("full_rel_ready", 64'(EVT_READY), 64'd1);

    // Timeout on second event, then next sample runs
    skip_en = 1'b1; skip_addr = 12'h0A2;
    for (int i = 1; i <= 5; i++) wr(12'h0A0 + 12'(i), i == 5);
    wr(12'h0B1, 1'b0); wr(12'h0B2, 1'b1);
    push(12'h0A1, 1'b1); push(12'h0A2, 1'b1);
    rv0 = rv_cnt; err0 = err_cnt;
    start_run(1'b1, 1'b0, 1'b0);
    k = 0;
    while (err_cnt == err0 && k < 400) begin tick(1); k++; end
    tick(1);
    chk("tmo_err_pulse", 64'(err_cnt - err0), 64'd1);
    chk("tmo_no_result", 64'(rv_cnt - rv0), 64'd0);
    chk("tmo_idle", {BUSY, AERIN_REQ}, 64'd0);
    skip_en = 1'b0;
    push(12'h0B1, 1'b1); push(12'h0B2, 1'b1);
    hs0 = hs_total;
    start_run(1'b1, 1'b0, 1'b0);
    wait_hs(hs0 + 2);
    finish_core(32'd77);
    check_done("after_tmo", 32'd77, '0);

    // Reset while waiting for ACK
    skip_en = 1'b1; skip_addr = 12'h0C1;
    wr(12'h0C1, 1'b0); wr(12'h0C2, 1'b1);
    push(12'h0C1, 1'b1);
    hs0 = hs_total;
    start_run(1'b1, 1'b0, 1'b0);
    wait_hs(hs0 + 1);
    tick(2);
    RST = 1'b0;
    #1;
    chk("wack_rst_outputs", {AERIN_REQ, BUSY, EVT_READY}, 64'd0);
    tick(2);
    RST = 1'b1;
    skip_en = 1'b0;
    tick(1);
    chk("wack_rel_ready", 64'(EVT_READY), 64'd1);
    start_run(1'b1, 1'b0, 1'b0);
    chk("wack_buffer_empty", 64'(BUSY), 64'd0);
    wr(12'h2AA, 1'b0); wr(12'h355, 1'b1);
    push(12'h2AA, 1'b0); push(12'h355, 1'b0);
    hs0 = hs_total;
    start_run(1'b0, 1'b1, 1'b0);
    chk("fresh_mode", {IS_POS, IS_TRAIN}, 64'd1);
    wait_hs(hs0 + 2);
    finish_core(32'hFFFF_FF9C);
    check_done("fresh", 32'hFFFF_FF9C, '0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
